// File: rtl/btn_pulse_conditioner.sv
// Push-button front end: per-channel synchroniser, debounce, press/release pulses
// and optional hold-to-repeat, all outputs registered.
module btn_pulse_conditioner #(
   parameter int N_BTN            = 4,
   parameter int ACTIVE_LOW_BTN   = 1,
   parameter int DEBOUNCE_CYC     = 500000,
   parameter int REPEAT_DELAY_CYC = 25000000,
   parameter int REPEAT_RATE_CYC  = 5000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   output logic [N_BTN-1:0] btn_release
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYC);
   localparam int TM_MAXC = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
   localparam int TM_W    = $clog2(TM_MAXC);

   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [TM_W-1:0]  DLY_LAST  = TM_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [TM_W-1:0]  RATE_LAST = TM_W'(REPEAT_RATE_CYC - 1);
   localparam logic [TM_W-1:0]  TM_SAT    = '1;
   // Released-pin value; syncs reset to it so no phantom press is counted after reset.
   localparam logic [N_BTN-1:0] IDLE_PIN  = (ACTIVE_LOW_BTN != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   function automatic logic [TM_W-1:0] sat_inc(input logic [TM_W-1:0] v);
      return (v == TM_SAT) ? v : v + TM_W'(1);
   endfunction

   logic [N_BTN-1:0] r_sync_p0, r_sync_p1;
   logic [N_BTN-1:0] w_s;
   logic [N_BTN-1:0] r_level;
   logic [DB_W-1:0]  r_db_cnt [N_BTN];
   logic [N_BTN-1:0] w_rise, w_fall;

   state_t           r_state     [N_BTN];
   state_t           w_state_nxt [N_BTN];
   logic [TM_W-1:0]  r_tmr       [N_BTN];
   logic [TM_W-1:0]  w_tmr_nxt   [N_BTN];
   logic [N_BTN-1:0] r_pulse, r_rel;
   logic [N_BTN-1:0] w_pulse_nxt, w_rel_nxt;

   assign w_s = r_sync_p1 ^ IDLE_PIN;

   // Stage p0/p1: synchroniser, then debounce on the pressed-polarity sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_p0 <= IDLE_PIN;
         r_sync_p1 <= IDLE_PIN;
         r_level   <= '0;
         for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync_p0 <= btn_raw;
         r_sync_p1 <= r_sync_p0;
         for (int i = 0; i < N_BTN; i++) begin
            if (w_s[i] == r_level[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db_cnt[i] <= '0;
               r_level[i]  <= ~r_level[i];
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Accept events are decoded one edge early so pulses line up with btn_level
   always_comb begin
      w_rise = '0;
      w_fall = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if ((w_s[i] != r_level[i]) && (r_db_cnt[i] == DB_LAST)) begin
            w_rise[i] = w_s[i];
            w_fall[i] = ~w_s[i];
         end
      end
   end

   always_comb begin
      w_pulse_nxt = '0;
      w_rel_nxt   = '0;
      for (int i = 0; i < N_BTN; i++) begin
         w_state_nxt[i] = r_state[i];
         w_tmr_nxt[i]   = sat_inc(r_tmr[i]);
         case (r_state[i])
            ST_IDLE: begin
               if (w_rise[i]) begin
                  w_pulse_nxt[i] = 1'b1;
                  w_tmr_nxt[i]   = '0;
                  w_state_nxt[i] = ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (w_fall[i]) begin
                  w_rel_nxt[i]   = 1'b1;
                  w_state_nxt[i] = ST_IDLE;
               end else if (repeat_en[i] && (r_tmr[i] >= DLY_LAST)) begin
                  w_pulse_nxt[i] = 1'b1;
                  w_tmr_nxt[i]   = '0;
                  w_state_nxt[i] = ST_REPEAT;
               end
            end
            ST_REPEAT: begin
               if (w_fall[i]) begin
                  w_rel_nxt[i]   = 1'b1;
                  w_state_nxt[i] = ST_IDLE;
               end else if (!repeat_en[i]) begin
                  // Saturated timer makes a later re-enable fire at once
                  w_tmr_nxt[i]   = TM_SAT;
                  w_state_nxt[i] = ST_DELAY;
               end else if (r_tmr[i] >= RATE_LAST) begin
                  w_pulse_nxt[i] = 1'b1;
                  w_tmr_nxt[i]   = '0;
               end
            end
            default: w_state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   // Stage p2: FSM state and registered pulse outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pulse <= '0;
         r_rel   <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            r_state[i] <= ST_IDLE;
            r_tmr[i]   <= '0;
         end
      end else begin
         r_pulse <= w_pulse_nxt;
         r_rel   <= w_rel_nxt;
         for (int i = 0; i < N_BTN; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_tmr[i]   <= w_tmr_nxt[i];
         end
      end
   end

   assign btn_level   = r_level;
   assign btn_pulse   = r_pulse;
   assign btn_release = r_rel;

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench for btn_pulse_conditioner with short debounce/repeat timings.
module tb_btn_pulse_conditioner;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] btn_raw = 4'hF;
   logic [3:0] repeat_en = 4'h0;
   logic [3:0] btn_level, btn_pulse, btn_release;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   btn_pulse_conditioner #(
      .N_BTN(4), .ACTIVE_LOW_BTN(1), .DEBOUNCE_CYC(4),
      .REPEAT_DELAY_CYC(10), .REPEAT_RATE_CYC(3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .repeat_en(repeat_en),
      .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (btn_level !== 4'b0000) begin n_err++; $display("FAIL reset_level: got %b expected 0000", btn_level); end
      n_cmp++; if (btn_pulse !== 4'b0000) begin n_err++; $display("FAIL reset_pulse: got %b expected 0000", btn_pulse); end
      n_cmp++; if (btn_release !== 4'b0000) begin n_err++; $display("FAIL reset_release: got %b expected 0000", btn_release); end
      tick(3);
      reset_n = 1'b1;
      tick(10);
      n_cmp++; if ({btn_level, btn_pulse, btn_release} !== 12'h000) begin n_err++; $display("FAIL post_reset_idle: got %b expected all 0", {btn_level, btn_pulse, btn_release}); end
   endtask

   task automatic test_single_press();
      int pulses = 0;
      btn_raw[0] = 1'b0;
      tick(5);
      n_cmp++; if (btn_pulse !== 4'b0000) begin n_err++; $display("FAIL press_early: pulse=%b expected 0000", btn_pulse); end
      n_cmp++; if (btn_level !== 4'b0000) begin n_err++; $display("FAIL press_early_level: level=%b expected 0000", btn_level); end
      tick(1);
      n_cmp++; if (btn_pulse !== 4'b0001) begin n_err++; $display("FAIL press_pulse: pulse=%b expected 0001", btn_pulse); end
      n_cmp++; if (btn_level !== 4'b0001) begin n_err++; $display("FAIL press_level: level=%b expected 0001", btn_level); end
      for (int j = 0; j < 40; j++) begin
         tick(1);
         if (btn_pulse[0]) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL hold_no_repeat: pulses=%0d expected 0", pulses); end
      btn_raw[0] = 1'b1;
      tick(5);
      n_cmp++; if (btn_release !== 4'b0000) begin n_err++; $display("FAIL release_early: release=%b expected 0000", btn_release); end
      tick(1);
      n_cmp++; if (btn_release !== 4'b0001) begin n_err++; $display("FAIL release_pulse: release=%b expected 0001", btn_release); end
      n_cmp++; if (btn_level !== 4'b0000) begin n_err++; $display("FAIL release_level: level=%b expected 0000", btn_level); end
      tick(1);
      n_cmp++; if (btn_release !== 4'b0000) begin n_err++; $display("FAIL release_one_cycle: release=%b expected 0000", btn_release); end
   endtask

   task automatic test_glitch();
      int seen = 0;
      btn_raw[1] = 1'b0;
      tick(3);
      btn_raw[1] = 1'b1;
      for (int j = 0; j < 10; j++) begin
         tick(1);
         if (btn_level[1] || btn_pulse[1]) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL glitch_3cyc: active cycles=%0d expected 0", seen); end
      btn_raw[1] = 1'b0; tick(1);
      btn_raw[1] = 1'b1; tick(1);
      btn_raw[1] = 1'b0;
      tick(5);
      n_cmp++; if (btn_pulse !== 4'b0000) begin n_err++; $display("FAIL bounce_early: pulse=%b expected 0000", btn_pulse); end
      tick(1);
      n_cmp++; if (btn_pulse !== 4'b0010) begin n_err++; $display("FAIL bounce_pulse: pulse=%b expected 0010", btn_pulse); end
      btn_raw[1] = 1'b1;
      tick(8);
      n_cmp++; if (btn_level !== 4'b0000) begin n_err++; $display("FAIL bounce_release_level: level=%b expected 0000", btn_level); end
   endtask

   task automatic test_repeat();
      logic exp_p, exp_r;
      repeat_en[2] = 1'b1;
      btn_raw[2] = 1'b0;
      tick(6);
      n_cmp++; if (btn_pulse !== 4'b0100) begin n_err++; $display("FAIL repeat_first: pulse=%b expected 0100", btn_pulse); end
      for (int j = 1; j <= 40; j++) begin
         tick(1);
         exp_p = (j >= 10) && (j < 36) && (((j - 10) % 3) == 0);
         exp_r = (j == 36);
         n_cmp++; if (btn_pulse[2] !== exp_p) begin n_err++; $display("FAIL repeat_pulse T+%0d: got %b expected %b", j, btn_pulse[2], exp_p); end
         n_cmp++; if (btn_release[2] !== exp_r) begin n_err++; $display("FAIL repeat_release T+%0d: got %b expected %b", j, btn_release[2], exp_r); end
         if (j == 30) btn_raw[2] = 1'b1;
      end
      repeat_en[2] = 1'b0;
   endtask

   task automatic test_repeat_pause();
      logic exp_p;
      repeat_en[1] = 1'b1;
      btn_raw[1] = 1'b0;
      tick(6);
      n_cmp++; if (btn_pulse !== 4'b0010) begin n_err++; $display("FAIL pause_first: pulse=%b expected 0010", btn_pulse); end
      for (int j = 1; j <= 25; j++) begin
         tick(1);
         exp_p = (j == 10) || (j == 21) || (j == 24);
         n_cmp++; if (btn_pulse[1] !== exp_p) begin n_err++; $display("FAIL pause_pulse T+%0d: got %b expected %b", j, btn_pulse[1], exp_p); end
         if (j == 11) repeat_en[1] = 1'b0;
         if (j == 20) repeat_en[1] = 1'b1;
      end
      repeat_en[1] = 1'b0;
      btn_raw[1] = 1'b1;
      tick(8);
   endtask

   task automatic test_simultaneous();
      btn_raw[0] = 1'b0;
      btn_raw[3] = 1'b0;
      tick(6);
      n_cmp++; if (btn_pulse !== 4'b1001) begin n_err++; $display("FAIL simul_pulse: pulse=%b expected 1001", btn_pulse); end
      n_cmp++; if (btn_level !== 4'b1001) begin n_err++; $display("FAIL simul_level: level=%b expected 1001", btn_level); end
      btn_raw[0] = 1'b1;
      tick(6);
      n_cmp++; if (btn_release !== 4'b0001) begin n_err++; $display("FAIL simul_release: release=%b expected 0001", btn_release); end
      n_cmp++; if (btn_level !== 4'b1000) begin n_err++; $display("FAIL simul_after_level: level=%b expected 1000", btn_level); end
      btn_raw[3] = 1'b1;
      tick(8);
   endtask

   task automatic test_reset_mid_repeat();
      int pulses = 0;
      repeat_en[2] = 1'b1;
      btn_raw[2] = 1'b0;
      tick(6 + 12);
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({btn_level, btn_pulse, btn_release} !== 12'h000) begin n_err++; $display("FAIL midreset_outputs: got %b expected all 0", {btn_level, btn_pulse, btn_release}); end
      tick(1);
      reset_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick(1);
         if (btn_pulse[2] || btn_level[2]) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midreset_quiet: active cycles=%0d expected 0", pulses); end
      tick(1);
      n_cmp++; if (btn_pulse !== 4'b0100) begin n_err++; $display("FAIL midreset_fresh_press: pulse=%b expected 0100", btn_pulse); end
      repeat_en[2] = 1'b0;
      btn_raw[2] = 1'b1;
      tick(8);
   endtask

   task automatic test_release_at_expiry();
      int early = 0;
      repeat_en[0] = 1'b1;
      btn_raw[0] = 1'b0;
      tick(6);
      n_cmp++; if (btn_pulse !== 4'b0001) begin n_err++; $display("FAIL coincide_press: pulse=%b expected 0001", btn_pulse); end
      tick(4);
      btn_raw[0] = 1'b1;
      for (int j = 5; j <= 9; j++) begin
         tick(1);
         if (btn_pulse[0] || btn_release[0]) early++;
      end
      n_cmp++; if (early !== 0) begin n_err++; $display("FAIL coincide_early: active cycles=%0d expected 0", early); end
      tick(1);
      n_cmp++; if (btn_release !== 4'b0001) begin n_err++; $display("FAIL coincide_release: release=%b expected 0001", btn_release); end
      n_cmp++; if (btn_pulse !== 4'b0000) begin n_err++; $display("FAIL coincide_no_pulse: pulse=%b expected 0000", btn_pulse); end
      tick(1);
      n_cmp++; if (btn_pulse !== 4'b0000) begin n_err++; $display("FAIL coincide_after: pulse=%b expected 0000", btn_pulse); end
      repeat_en[0] = 1'b0;
      tick(4);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_repeat();
      test_repeat_pause();
      test_simultaneous();
      test_reset_mid_repeat();
      test_release_at_expiry();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
